// File: rtl/ycr_memif_pkg.sv
// Shared encodings and helpers for the imem prefetch path.
// Response/command/width codes, the prefetch FSM state type and
// DEPTH-derived width helpers used by the prefetcher and its line buffer.
package ycr_memif_pkg;

    localparam logic [1:0] YCR_RESP_NOTRDY = 2'b00;
    localparam logic [1:0] YCR_RESP_RDY_OK = 2'b01;
    localparam logic [1:0] YCR_RESP_RDY_ER = 2'b10;

    localparam logic       YCR_CMD_RD      = 1'b0;
    localparam logic       YCR_CMD_WR      = 1'b1;

    localparam logic [1:0] YCR_WIDTH_WORD  = 2'b10;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_REQ  = 2'd1,
        PF_FILL = 2'd2
    } type_ycr_pf_fsm_e;

    // Bits needed to index a word inside a line of 'depth' words.
    function automatic int pf_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Byte-offset bits covered by one line of 'depth' 32-bit words.
    function automatic int pf_off_w(input int depth);
        return $clog2(depth * 4);
    endfunction

endpackage

// File: rtl/ycr_pf_line_buf.sv
// One prefetch line: DEPTH words of storage plus a valid bit per word.
// Clear wins over write; the read port is combinational on stored state,
// so a read in the same cycle as a write returns the pre-write contents.
module ycr_pf_line_buf
    import ycr_memif_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [DW-1:0]    wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [DW-1:0]    rd_data,
    output logic [DEPTH-1:0] vld
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];

    // Next line contents: invalidate everything, or write one word and mark it valid.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr) begin
            vld_d = '0;
        end else if (wr_en) begin
            vld_d[wr_idx]  = 1'b1;
            data_d[wr_idx] = wr_data;
        end
    end

    // Line storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign rd_data = data_q[rd_idx];
    assign vld     = vld_q;

endmodule

// File: rtl/ycr_imem_prefetch.sv
// Single-line instruction prefetch buffer between the core imem port and
// the icache router. A read miss fetches the whole aligned line as one
// burst; hits (including to words already landed mid-burst) are answered
// from the line buffer with a registered response one cycle after ack.
// Optional feature macro: YCR_IMEM_PF_NEXTLINE_EN -- a hit to the last word
// of the line while idle starts a fill of the following line.
//
// Handshake: core_req is held by the core until core_req_ack (combinational)
// is high in the same cycle; the response appears on core_resp/core_rdata in
// the following cycle only. pf_req is held until pf_req_ack is sampled high.
module ycr_imem_prefetch
    import ycr_memif_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int BLW   = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           core_req,
    output logic           core_req_ack,
    input  logic           core_cmd,
    input  logic [1:0]     core_width,
    input  logic [AW-1:0]  core_addr,
    output logic [DW-1:0]  core_rdata,
    output logic [1:0]     core_resp,
    output logic           pf_req,
    input  logic           pf_req_ack,
    output logic           pf_cmd,
    output logic [1:0]     pf_width,
    output logic [AW-1:0]  pf_addr,
    output logic [BLW-1:0] pf_bl,
    input  logic [DW-1:0]  pf_rdata,
    input  logic [1:0]     pf_resp,
    output logic [1:0]     dbg_state
);

    localparam int IDX_W      = pf_idx_w(DEPTH);
    localparam int OFF_W      = pf_off_w(DEPTH);
    localparam int LINE_BYTES = DEPTH * 4;

    type_ycr_pf_fsm_e state_q, state_d;
    logic [AW-1:0]    line_addr_q, line_addr_d;
    logic             tag_vld_q, tag_vld_d;
    logic             err_line_q, err_line_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             pf_req_q, pf_req_d;
    logic [AW-1:0]    pf_addr_q, pf_addr_d;
    logic [1:0]       core_resp_q, core_resp_d;
    logic [DW-1:0]    core_rdata_q, core_rdata_d;
    logic             nl_pend_q, nl_pend_d;

    logic [AW-1:0]    req_line;
    logic [IDX_W-1:0] req_idx;
    logic             tag_match;
    logic             hit;
    logic             err_hit;
    logic             wr_req;
    logic             rd_miss;
    logic             start_fill;
    logic [AW-1:0]    fill_addr;
    logic             buf_clr;
    logic             buf_wr;
    logic [DW-1:0]    buf_rd_data;
    logic [DEPTH-1:0] buf_vld;
    logic             unused_in;

    // Width and byte-lane bits never matter: every access is a full word.
    assign unused_in = ^{core_width, core_addr[1:0]};

    assign req_line  = {core_addr[AW-1:OFF_W], {OFF_W{1'b0}}};
    assign req_idx   = core_addr[2 +: IDX_W];
    assign tag_match = tag_vld_q & (line_addr_q == req_line);
    assign hit       = core_req & (core_cmd == YCR_CMD_RD) & tag_match & buf_vld[req_idx];
    assign err_hit   = core_req & (core_cmd == YCR_CMD_RD) & err_line_q & tag_match & ~buf_vld[req_idx];
    assign wr_req    = core_req & (core_cmd == YCR_CMD_WR);
    assign rd_miss   = core_req & (core_cmd == YCR_CMD_RD) & ~hit & ~err_hit;

    assign core_req_ack = hit | wr_req | err_hit;

    ycr_pf_line_buf #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .IW    (IDX_W)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_idx  (cnt_q),
        .wr_data (pf_rdata),
        .rd_idx  (req_idx),
        .rd_data (buf_rd_data),
        .vld     (buf_vld)
    );

    // Fill sequencing: start a line fetch, wait for the downstream accept, collect beats.
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        tag_vld_d   = tag_vld_q;
        err_line_d  = err_line_q;
        cnt_d       = cnt_q;
        pf_req_d    = pf_req_q;
        pf_addr_d   = pf_addr_q;
        nl_pend_d   = 1'b0;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        start_fill  = 1'b0;
        fill_addr   = req_line;

        // An error answer retires the failed line so the next fetch refills it.
        if (err_hit) begin
            err_line_d = 1'b0;
            tag_vld_d  = 1'b0;
        end

        case (state_q)
            PF_IDLE: begin
                if (nl_pend_q) begin
                    start_fill = 1'b1;
                    fill_addr  = line_addr_q + AW'(LINE_BYTES);
                end else if (rd_miss) begin
                    start_fill = 1'b1;
                end
`ifdef YCR_IMEM_PF_NEXTLINE_EN
                if (hit && (req_idx == IDX_W'(DEPTH - 1)) && !nl_pend_q) begin
                    nl_pend_d = 1'b1;
                end
`endif
            end
            PF_REQ: begin
                if (pf_req_ack) begin
                    cnt_d    = '0;
                    pf_req_d = 1'b0;
                    state_d  = PF_FILL;
                end
            end
            PF_FILL: begin
                if (pf_resp == YCR_RESP_RDY_OK) begin
                    buf_wr = 1'b1;
                    cnt_d  = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_d = PF_IDLE;
                    end
                end else if (pf_resp == YCR_RESP_RDY_ER) begin
                    buf_clr    = 1'b1;
                    err_line_d = 1'b1;
                    state_d    = PF_IDLE;
                end
            end
            default: state_d = PF_IDLE;
        endcase

        if (start_fill) begin
            state_d     = PF_REQ;
            line_addr_d = fill_addr;
            pf_addr_d   = fill_addr;
            pf_req_d    = 1'b1;
            tag_vld_d   = 1'b1;
            err_line_d  = 1'b0;
            buf_clr     = 1'b1;
        end
    end

    // Core response for the cycle after an ack; idle cycles read back as NOTRDY.
    always_comb begin
        core_resp_d  = YCR_RESP_NOTRDY;
        core_rdata_d = '0;
        if (hit) begin
            core_resp_d  = YCR_RESP_RDY_OK;
            core_rdata_d = buf_rd_data;
        end else if (wr_req || err_hit) begin
            core_resp_d  = YCR_RESP_RDY_ER;
        end
    end

    // State, tag and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PF_IDLE;
            line_addr_q  <= '0;
            tag_vld_q    <= 1'b0;
            err_line_q   <= 1'b0;
            cnt_q        <= '0;
            pf_req_q     <= 1'b0;
            pf_addr_q    <= '0;
            core_resp_q  <= YCR_RESP_NOTRDY;
            core_rdata_q <= '0;
            nl_pend_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            tag_vld_q    <= tag_vld_d;
            err_line_q   <= err_line_d;
            cnt_q        <= cnt_d;
            pf_req_q     <= pf_req_d;
            pf_addr_q    <= pf_addr_d;
            core_resp_q  <= core_resp_d;
            core_rdata_q <= core_rdata_d;
            nl_pend_q    <= nl_pend_d;
        end
    end

    assign core_resp  = core_resp_q;
    assign core_rdata = core_rdata_q;
    assign pf_req     = pf_req_q;
    assign pf_addr    = pf_addr_q;
    assign pf_cmd     = YCR_CMD_RD;
    assign pf_width   = YCR_WIDTH_WORD;
    assign pf_bl      = BLW'(DEPTH);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ycr_imem_prefetch.sv
// Directed bench for ycr_imem_prefetch (DEPTH = 4): cold miss, sequential
// hits, hit during fill, error line, writes, reset mid-burst and, when
// YCR_IMEM_PF_NEXTLINE_EN is defined, next-line prefetch with address wrap.
module tb_ycr_imem_prefetch;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BLW   = 3;

    localparam logic [1:0] R_NOTRDY = 2'b00;
    localparam logic [1:0] R_OK     = 2'b01;
    localparam logic [1:0] R_ER     = 2'b10;

    logic           clk = 1'b0;
    logic           rst;
    logic           core_req;
    logic           core_req_ack;
    logic           core_cmd;
    logic [1:0]     core_width;
    logic [AW-1:0]  core_addr;
    logic [DW-1:0]  core_rdata;
    logic [1:0]     core_resp;
    logic           pf_req;
    logic           pf_req_ack;
    logic           pf_cmd;
    logic [1:0]     pf_width;
    logic [AW-1:0]  pf_addr;
    logic [BLW-1:0] pf_bl;
    logic [DW-1:0]  pf_rdata;
    logic [1:0]     pf_resp;
    logic [1:0]     dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Downstream burst script and observations
    logic [1:0]    beat_resp [DEPTH];
    logic [DW-1:0] beat_data [DEPTH];
    int            beat_cyc  [DEPTH];
    int            beat_gap  = 0;
    int            beats_sent = 0;
    int            req_cnt   = 0;
    bit            ds_busy   = 1'b0;
    logic [AW-1:0] req_addr_q [$];

    ycr_imem_prefetch #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .BLW   (BLW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req     (core_req),
        .core_req_ack (core_req_ack),
        .core_cmd     (core_cmd),
        .core_width   (core_width),
        .core_addr    (core_addr),
        .core_rdata   (core_rdata),
        .core_resp    (core_resp),
        .pf_req       (pf_req),
        .pf_req_ack   (pf_req_ack),
        .pf_cmd       (pf_cmd),
        .pf_width     (pf_width),
        .pf_addr      (pf_addr),
        .pf_bl        (pf_bl),
        .pf_rdata     (pf_rdata),
        .pf_resp      (pf_resp),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_beats(input logic [DW-1:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            beat_data[i] = base + DW'(i);
            beat_resp[i] = R_OK;
        end
    endtask

    // Pops the next recorded burst address and compares it.
    task automatic check_req(input string tag, input logic [AW-1:0] exp);
        logic [AW-1:0] got;
        got = 'x;
        if (req_addr_q.size() > 0) got = req_addr_q.pop_front();
        check_eq(tag, got, exp);
    endtask

    // Called on a negedge; returns on a negedge.
    task automatic do_fetch(input string tag, input logic cmd, input logic [AW-1:0] addr,
                            input logic [1:0] exp_resp, input logic [DW-1:0] exp_data,
                            input bit chk_data, output int start_cyc, output int ack_cyc);
        bit got;
        got       = 1'b0;
        core_req  = 1'b1;
        core_cmd  = cmd;
        core_addr = addr;
        #1;
        start_cyc = cyc;
        for (int k = 0; k < 200; k++) begin
            if (core_req_ack) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check_eq({tag, "_acked"}, 64'(got), 64'd1);
        ack_cyc = cyc;
        @(posedge clk);
        #1;
        core_req = 1'b0;
        check_eq({tag, "_resp"}, 64'(core_resp), 64'(exp_resp));
        if (chk_data) check_eq({tag, "_data"}, 64'(core_rdata), 64'(exp_data));
        @(posedge clk);
        #1;
        check_eq({tag, "_resp_clr"}, 64'(core_resp), 64'(R_NOTRDY));
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (dbg_state == 2'd0 && !ds_busy) begin
                done = 1'b1;
                break;
            end
        end
        check_eq({tag, "_idle"}, 64'(done), 64'd1);
        @(negedge clk);
    endtask

    // Downstream model: accepts each burst request, then plays the beat script.
    initial begin
        bit abort;
        pf_req_ack = 1'b0;
        pf_resp    = R_NOTRDY;
        pf_rdata   = '0;
        forever begin
            @(negedge clk);
            pf_req_ack = 1'b0;
            if (!rst && pf_req) begin
                ds_busy = 1'b1;
                req_cnt++;
                req_addr_q.push_back(pf_addr);
                check_eq("pf_bl", 64'(pf_bl), 64'd4);
                check_eq("pf_cmd", 64'(pf_cmd), 64'd0);
                check_eq("pf_width", 64'(pf_width), 64'd2);
                pf_req_ack = 1'b1;
                @(negedge clk);
                pf_req_ack = 1'b0;
                abort = 1'b0;
                for (int i = 0; i < DEPTH && !abort; i++) begin
                    for (int g = 0; g < beat_gap && !abort; g++) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    if (rst) abort = 1'b1;
                    if (!abort) begin
                        pf_resp     = beat_resp[i];
                        pf_rdata    = beat_data[i];
                        beat_cyc[i] = cyc;
                        beats_sent++;
                        @(negedge clk);
                        pf_resp  = R_NOTRDY;
                        pf_rdata = '0;
                        if (beat_resp[i] == R_ER || rst) abort = 1'b1;
                    end
                end
                ds_busy = 1'b0;
            end
        end
    end

    // Directed sequence
    initial begin
        int s_cyc, a_cyc, n_before, bs0;
        bit seen;
        rst        = 1'b1;
        core_req   = 1'b0;
        core_cmd   = 1'b0;
        core_width = 2'b10;
        core_addr  = '0;
        set_beats(32'hA0);

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ack", 64'(core_req_ack), 64'd0);
        check_eq("rst_resp", 64'(core_resp), 64'(R_NOTRDY));
        check_eq("rst_rdata", 64'(core_rdata), 64'd0);
        check_eq("rst_pf_req", 64'(pf_req), 64'd0);
        check_eq("rst_pf_addr", 64'(pf_addr), 64'd0);
        check_eq("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Cold fetch
        do_fetch("cold", 1'b0, 32'h100, R_OK, 32'hA0, 1'b1, s_cyc, a_cyc);
        check_eq("cold_lat", 64'(a_cyc), 64'(beat_cyc[0] + 1));
        check_req("cold_pf_addr", 32'h100);
        wait_idle("cold");

        // Sequential hits
        for (int i = 1; i < DEPTH; i++) begin
            do_fetch("seq_hit", 1'b0, 32'h100 + 32'(4 * i), R_OK, 32'hA0 + 32'(i), 1'b1, s_cyc, a_cyc);
            check_eq("seq_hit_lat", 64'(a_cyc), 64'(s_cyc));
        end
        repeat (3) @(negedge clk);
`ifndef YCR_IMEM_PF_NEXTLINE_EN
        check_eq("seq_no_pf_req", 64'(req_cnt), 64'd1);
`endif
        wait_idle("seq");
        req_addr_q.delete();
        n_before = req_cnt;

        // Hit while the fill is still in flight
        set_beats(32'hB0);
        beat_gap = 3;
        do_fetch("early", 1'b0, 32'h304, R_OK, 32'hB1, 1'b1, s_cyc, a_cyc);
        check_eq("early_lat", 64'(a_cyc), 64'(beat_cyc[1] + 1));
        check_req("early_pf_addr", 32'h300);
        wait_idle("early");
        beat_gap = 0;
        do_fetch("early_after", 1'b0, 32'h308, R_OK, 32'hB2, 1'b1, s_cyc, a_cyc);

        // Error beat, then refetch
        set_beats(32'hC0);
        beat_resp[2] = R_ER;
        do_fetch("err_first", 1'b0, 32'h200, R_OK, 32'hC0, 1'b1, s_cyc, a_cyc);
        do_fetch("err_word", 1'b0, 32'h208, R_ER, 32'h0, 1'b0, s_cyc, a_cyc);
        check_req("err_pf_addr", 32'h200);
        wait_idle("err");
        set_beats(32'hD0);
        do_fetch("err_refetch", 1'b0, 32'h208, R_OK, 32'hD2, 1'b1, s_cyc, a_cyc);
        check_req("err_refetch_addr", 32'h200);
        check_eq("err_req_cnt", 64'(req_cnt), 64'(n_before + 3));
        wait_idle("err2");

        // Writes: immediate error ack, no downstream traffic
        n_before = req_cnt;
        do_fetch("write", 1'b1, 32'h500, R_ER, 32'h0, 1'b0, s_cyc, a_cyc);
        check_eq("write_lat", 64'(a_cyc), 64'(s_cyc));
        do_fetch("write_line", 1'b1, 32'h204, R_ER, 32'h0, 1'b0, s_cyc, a_cyc);
        repeat (3) @(negedge clk);
        check_eq("write_no_pf", 64'(req_cnt), 64'(n_before));

        // Reset in the middle of a fill
        set_beats(32'hE0);
        beat_gap = 4;
        bs0 = beats_sent;
        core_req  = 1'b1;
        core_cmd  = 1'b0;
        core_addr = 32'h600;
        #1;
        check_eq("miss_no_ack", 64'(core_req_ack), 64'd0);
        check_eq("miss_pf_req_n", 64'(pf_req), 64'd0);
        @(negedge clk);
        core_req = 1'b0;
        #1;
        check_eq("miss_pf_req_n1", 64'(pf_req), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (beats_sent > bs0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rst_mid_beat0", 64'(seen), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_pf_req", 64'(pf_req), 64'd0);
        check_eq("rst_mid_state", 64'(dbg_state), 64'd0);
        check_eq("rst_mid_resp", 64'(core_resp), 64'(R_NOTRDY));
        wait_idle("rst_mid");
        check_req("rst_mid_pf_addr", 32'h600);
        beat_gap = 0;
        set_beats(32'h70);
        n_before = req_cnt;
        do_fetch("rst_refetch", 1'b0, 32'h600, R_OK, 32'h70, 1'b1, s_cyc, a_cyc);
        check_eq("rst_refetch_cnt", 64'(req_cnt), 64'(n_before + 1));
        check_req("rst_refetch_addr", 32'h600);
        wait_idle("rst_refetch");

`ifdef YCR_IMEM_PF_NEXTLINE_EN
        // Next-line prefetch from the top line wraps to address 0
        set_beats(32'h80);
        do_fetch("nl_top", 1'b0, 32'hFFFF_FFF0, R_OK, 32'h80, 1'b1, s_cyc, a_cyc);
        wait_idle("nl_top");
        check_req("nl_top_addr", 32'hFFFF_FFF0);
        set_beats(32'h90);
        n_before = req_cnt;
        do_fetch("nl_last", 1'b0, 32'hFFFF_FFFC, R_OK, 32'h83, 1'b1, s_cyc, a_cyc);
        check_eq("nl_last_lat", 64'(a_cyc), 64'(s_cyc));
        wait_idle("nl_wrap");
        check_eq("nl_req_cnt", 64'(req_cnt), 64'(n_before + 1));
        check_req("nl_wrap_addr", 32'h0);
        do_fetch("nl_hit0", 1'b0, 32'h0, R_OK, 32'h90, 1'b1, s_cyc, a_cyc);
        check_eq("nl_hit0_lat", 64'(a_cyc), 64'(s_cyc));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
